// File: rtl/ccr_branch_unit_pkg.sv
// Shared definitions for the execute-stage condition-code unit.
//   - CCR bit positions {NF,OF,CF,ZF}
//   - ALU opcode encodings seen on aluSignals
//   - FSM state type for freeze/restore tracking
package ccr_branch_unit_pkg;

    localparam int CCR_W = 4;

    // CCR bit positions
    localparam int CCR_ZF = 0;
    localparam int CCR_CF = 1;
    localparam int CCR_OF = 2;
    localparam int CCR_NF = 3;

    // ALU operation codes
    localparam logic [4:0] ALU_NOP  = 5'd0;
    localparam logic [4:0] ALU_ADD  = 5'd1;
    localparam logic [4:0] ALU_SUB  = 5'd2;
    localparam logic [4:0] ALU_AND  = 5'd3;
    localparam logic [4:0] ALU_OR   = 5'd4;
    localparam logic [4:0] ALU_NOT  = 5'd5;
    localparam logic [4:0] ALU_INC  = 5'd6;
    localparam logic [4:0] ALU_SETC = 5'd7;
    localparam logic [4:0] ALU_CLRC = 5'd8;
    localparam logic [4:0] ALU_JZ   = 5'd9;
    localparam logic [4:0] ALU_JN   = 5'd10;
    localparam logic [4:0] ALU_JC   = 5'd11;
    localparam logic [4:0] ALU_JMP  = 5'd12;
    localparam logic [4:0] ALU_RTI  = 5'd13;
    localparam logic [4:0] ALU_CALL = 5'd14;
    localparam logic [4:0] ALU_RET  = 5'd15;

    typedef enum logic {
        CCR_IDLE   = 1'b0,
        CCR_FROZEN = 1'b1
    } ccr_state_e;

endpackage

// File: rtl/ccr_branch_unit_if.sv
// Bundle between the EX stage/ALU and the CCR branch unit.
//   master: EX-stage side, drives opcode/valid/stall/next flags/intEntry
//   slave : the CCR unit, returns current CCR, frozen copy, branch pulse,
//           frozen status and sticky interrupt overrun
interface ccr_branch_unit_if;
    import ccr_branch_unit_pkg::*;

    logic [4:0]       aluSignals;
    logic             validEx;
    logic             stall;
    logic [CCR_W-1:0] flagsIn;
    logic             intEntry;
    logic [CCR_W-1:0] flagsOut;
    logic [CCR_W-1:0] freezedCCR;
    logic             branchTaken;
    logic             frozen;
    logic             intOverrun;

    modport master (
        output aluSignals, validEx, stall, flagsIn, intEntry,
        input  flagsOut, freezedCCR, branchTaken, frozen, intOverrun
    );

    modport slave (
        input  aluSignals, validEx, stall, flagsIn, intEntry,
        output flagsOut, freezedCCR, branchTaken, frozen, intOverrun
    );
endinterface

// File: rtl/ccr_branch_unit_branch_cond_eval.sv
// Combinational branch-condition decode.
//   op_i    : ALU opcode of the instruction in EX
//   ccr_i   : CCR value before this instruction's update
//   taken_o : 1 when the opcode is a branch whose condition holds
module ccr_branch_unit_branch_cond_eval
    import ccr_branch_unit_pkg::*;
(
    input  logic [4:0]       op_i,
    input  logic [CCR_W-1:0] ccr_i,
    output logic             taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (op_i)
            ALU_JZ:  taken_o = ccr_i[CCR_ZF];
            ALU_JN:  taken_o = ccr_i[CCR_NF];
            ALU_JC:  taken_o = ccr_i[CCR_CF];
            ALU_JMP: taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/ccr_branch_unit.sv
// Execute-stage condition-code register with interrupt freeze/restore and
// conditional branch resolution.
//   clk  : system clock, rising edge
//   rstN : asynchronous active-low reset
//   bus  : slave side of ccr_branch_unit_if (opcode, valid, stall, next
//          flags, intEntry in; CCR, frozen CCR, branch pulse, frozen,
//          intOverrun out)
module ccr_branch_unit
    import ccr_branch_unit_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    ccr_branch_unit_if.slave  bus
);
    logic [CCR_W-1:0] ccr_q;
    logic [CCR_W-1:0] ccr_d;
    logic [CCR_W-1:0] freezed_q;
    logic             branch_q;
    logic             overrun_q;
    ccr_state_e       state_q;

    logic commit;
    logic taken;
    logic is_rti;

    assign commit = bus.validEx & ~bus.stall;
    assign is_rti = (bus.aluSignals == ALU_RTI);
    // The ALU already folds pass-through and flag clearing into flagsIn.
    assign ccr_d  = commit ? bus.flagsIn : ccr_q;

    // Branch condition looks at the CCR before this instruction's write.
    ccr_branch_unit_branch_cond_eval u_cond (
        .op_i    (bus.aluSignals),
        .ccr_i   (ccr_q),
        .taken_o (taken)
    );

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ccr_q     <= '0;
            freezed_q <= '0;
            branch_q  <= 1'b0;
            overrun_q <= 1'b0;
            state_q   <= CCR_IDLE;
        end else begin
            ccr_q    <= ccr_d;
            branch_q <= commit & taken;
            case (state_q)
                CCR_IDLE: begin
                    // Snapshot includes a same-cycle commit.
                    if (bus.intEntry) begin
                        freezed_q <= ccr_d;
                        state_q   <= CCR_FROZEN;
                    end
                end
                CCR_FROZEN: begin
                    // A second interrupt cannot be nested; flag it and keep
                    // the original snapshot. RTI still returns to IDLE.
                    if (bus.intEntry)
                        overrun_q <= 1'b1;
                    if (commit && is_rti)
                        state_q <= CCR_IDLE;
                end
                default: state_q <= CCR_IDLE;
            endcase
        end
    end

    assign bus.flagsOut    = ccr_q;
    assign bus.freezedCCR  = freezed_q;
    assign bus.branchTaken = branch_q;
    assign bus.frozen      = (state_q == CCR_FROZEN);
    assign bus.intOverrun  = overrun_q;
endmodule

// File: tb/tb_ccr_branch_unit.sv
module tb_ccr_branch_unit;
    import ccr_branch_unit_pkg::*;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    ccr_branch_unit_if bus();

    ccr_branch_unit dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0] m_ccr, m_fz;
    logic       m_frozen, m_ovr, m_br;

    function automatic logic cond_holds(input logic [4:0] op, input logic [3:0] c);
        if (op == ALU_JMP) return 1'b1;
        if (op == ALU_JZ)  return c[0];
        if (op == ALU_JN)  return c[3];
        if (op == ALU_JC)  return c[1];
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_ccr = 4'h0; m_fz = 4'h0; m_frozen = 1'b0; m_ovr = 1'b0; m_br = 1'b0;
    endtask

    // Drive one cycle of inputs, advance the model, land 1 time unit after the edge.
    task automatic step(input logic [4:0] op, input logic v, input logic s,
                        input logic [3:0] f, input logic ie);
        logic commit;
        logic [3:0] nxt;
        bus.aluSignals = op; bus.validEx = v; bus.stall = s;
        bus.flagsIn = f; bus.intEntry = ie;
        commit = v && !s;
        nxt = commit ? f : m_ccr;
        m_br = commit && cond_holds(op, m_ccr);
        if (!m_frozen) begin
            if (ie) begin m_frozen = 1'b1; m_fz = nxt; end
        end else begin
            if (ie) m_ovr = 1'b1;
            if (commit && op == ALU_RTI) m_frozen = 1'b0;
        end
        m_ccr = nxt;
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        rstN = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        model_reset();
        bus.aluSignals = ALU_ADD; bus.validEx = 1'b1; bus.stall = 1'b0;
        bus.flagsIn = 4'hF; bus.intEntry = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.flagsOut !== 4'h0) begin errors++; $display("FAIL reset_flags got=%h exp=0", bus.flagsOut); end
        checks++; if (bus.freezedCCR !== 4'h0) begin errors++; $display("FAIL reset_fz got=%h exp=0", bus.freezedCCR); end
        checks++; if (bus.branchTaken !== 1'b0) begin errors++; $display("FAIL reset_br got=%b exp=0", bus.branchTaken); end
        checks++; if (bus.frozen !== 1'b0 || bus.intOverrun !== 1'b0) begin errors++; $display("FAIL reset_fsm got frozen=%b ovr=%b exp 0/0", bus.frozen, bus.intOverrun); end
        rstN = 1'b1;
        step(ALU_ADD, 1, 0, 4'b0101, 0);
        checks++; if (bus.flagsOut !== 4'b0101) begin errors++; $display("FAIL first_commit got=%b exp=0101", bus.flagsOut); end
        $display("test_reset done: errors=%0d", errors);
    endtask

    task automatic test_branch();
        step(ALU_ADD, 1, 0, 4'b0001, 0);
        step(ALU_JZ, 1, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b1) begin errors++; $display("FAIL jz_taken got=%b exp=1", bus.branchTaken); end
        checks++; if (bus.flagsOut !== 4'b0000) begin errors++; $display("FAIL jz_clear got=%b exp=0000", bus.flagsOut); end
        step(ALU_NOP, 0, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b0) begin errors++; $display("FAIL br_one_cycle got=%b exp=0", bus.branchTaken); end
        step(ALU_JZ, 1, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b0) begin errors++; $display("FAIL jz_not_taken got=%b exp=0", bus.branchTaken); end
        step(ALU_JMP, 1, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b1) begin errors++; $display("FAIL jmp_taken got=%b exp=1", bus.branchTaken); end
        step(ALU_ADD, 1, 0, 4'b0010, 0);
        step(ALU_JC, 1, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b1) begin errors++; $display("FAIL jc_taken got=%b exp=1", bus.branchTaken); end
        $display("test_branch done: errors=%0d", errors);
    endtask

    task automatic test_stall();
        step(ALU_ADD, 1, 0, 4'b1000, 0);
        step(ALU_JN, 1, 1, 4'b0000, 0);
        checks++; if (bus.flagsOut !== 4'b1000) begin errors++; $display("FAIL stall_hold got=%b exp=1000", bus.flagsOut); end
        checks++; if (bus.branchTaken !== 1'b0) begin errors++; $display("FAIL stall_br got=%b exp=0", bus.branchTaken); end
        step(ALU_JN, 1, 0, 4'b0000, 0);
        checks++; if (bus.branchTaken !== 1'b1) begin errors++; $display("FAIL jn_after_stall got=%b exp=1", bus.branchTaken); end
        checks++; if (bus.flagsOut !== 4'b0000) begin errors++; $display("FAIL jn_clear got=%b exp=0000", bus.flagsOut); end
        $display("test_stall done: errors=%0d", errors);
    endtask

    task automatic test_freeze_restore();
        step(ALU_ADD, 1, 0, 4'b0110, 0);
        step(ALU_ADD, 1, 0, 4'b0010, 1);
        checks++; if (bus.freezedCCR !== 4'b0010) begin errors++; $display("FAIL freeze_val got=%b exp=0010", bus.freezedCCR); end
        checks++; if (bus.frozen !== 1'b1) begin errors++; $display("FAIL freeze_state got=%b exp=1", bus.frozen); end
        step(ALU_SETC, 1, 0, 4'b0011, 0);
        checks++; if (bus.flagsOut !== 4'b0011) begin errors++; $display("FAIL setc got=%b exp=0011", bus.flagsOut); end
        step(ALU_RTI, 1, 0, 4'b0010, 0);
        checks++; if (bus.flagsOut !== 4'b0010) begin errors++; $display("FAIL rti_flags got=%b exp=0010", bus.flagsOut); end
        checks++; if (bus.frozen !== 1'b0) begin errors++; $display("FAIL rti_state got=%b exp=0", bus.frozen); end
        // Freeze without commit snapshots the held CCR
        step(ALU_ADD, 1, 1, 4'b1111, 1);
        checks++; if (bus.freezedCCR !== 4'b0010) begin errors++; $display("FAIL freeze_stalled got=%b exp=0010", bus.freezedCCR); end
        step(ALU_RTI, 1, 0, 4'b0010, 0);
        $display("test_freeze_restore done: errors=%0d", errors);
    endtask

    task automatic test_overrun();
        step(ALU_ADD, 1, 0, 4'b0100, 1);
        step(ALU_NOP, 0, 0, 4'b0000, 1);
        checks++; if (bus.freezedCCR !== 4'b0100) begin errors++; $display("FAIL overrun_fz got=%b exp=0100", bus.freezedCCR); end
        checks++; if (bus.intOverrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", bus.intOverrun); end
        step(ALU_RTI, 1, 0, 4'b0100, 0);
        checks++; if (bus.intOverrun !== 1'b1 || bus.frozen !== 1'b0) begin errors++; $display("FAIL overrun_sticky got ovr=%b frozen=%b exp 1/0", bus.intOverrun, bus.frozen); end
        pulse_reset();
        checks++; if (bus.intOverrun !== 1'b0) begin errors++; $display("FAIL overrun_cleared got=%b exp=0", bus.intOverrun); end
        step(ALU_NOP, 0, 0, 4'b0000, 1);
        step(ALU_RTI, 1, 0, 4'b0001, 1);
        checks++; if (bus.frozen !== 1'b0 || bus.intOverrun !== 1'b1) begin errors++; $display("FAIL rti_int_same got frozen=%b ovr=%b exp 0/1", bus.frozen, bus.intOverrun); end
        $display("test_overrun done: errors=%0d", errors);
    endtask

    task automatic test_async_reset();
        step(ALU_ADD, 1, 0, 4'b1011, 1);
        step(ALU_JMP, 1, 0, 4'b1011, 0);
        #2;
        rstN = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.flagsOut !== 4'h0 || bus.freezedCCR !== 4'h0 || bus.branchTaken !== 1'b0 ||
            bus.frozen !== 1'b0 || bus.intOverrun !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got flags=%b fz=%b br=%b frozen=%b ovr=%b exp all 0",
                     bus.flagsOut, bus.freezedCCR, bus.branchTaken, bus.frozen, bus.intOverrun);
        end
        @(posedge clk); #1;
        rstN = 1'b1;
        $display("test_async_reset done: errors=%0d", errors);
    endtask

    task automatic test_random();
        logic [4:0] ops [0:8];
        ops[0] = ALU_NOP; ops[1] = ALU_ADD; ops[2] = ALU_SETC; ops[3] = ALU_JZ;
        ops[4] = ALU_JN;  ops[5] = ALU_JC;  ops[6] = ALU_JMP;  ops[7] = ALU_RTI;
        ops[8] = ALU_SUB;
        for (int i = 0; i < 400; i++) begin
            step(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) == 0), 4'($urandom), 1'($urandom_range(0, 9) == 0));
            if (i % 150 == 149) pulse_reset();
            checks++;
            if (bus.flagsOut !== m_ccr || bus.freezedCCR !== m_fz || bus.branchTaken !== m_br ||
                bus.frozen !== m_frozen || bus.intOverrun !== m_ovr) begin
                errors++;
                $display("FAIL random_%0d got flags=%b fz=%b br=%b frozen=%b ovr=%b exp flags=%b fz=%b br=%b frozen=%b ovr=%b",
                         i, bus.flagsOut, bus.freezedCCR, bus.branchTaken, bus.frozen, bus.intOverrun,
                         m_ccr, m_fz, m_br, m_frozen, m_ovr);
            end
        end
        $display("test_random done: errors=%0d", errors);
    endtask

    initial begin
        test_reset();
        test_branch();
        test_stall();
        test_freeze_restore();
        test_overrun();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ccr_branch_unit.md
Name: ccr_branch_unit

Overview:
- Execute-stage condition-code register (CCR) with interrupt freeze/restore and conditional-branch resolution.
- Feeds current flags and the frozen CCR copy to the ALU; consumes the ALU's next-flag outputs.
- Issues a registered one-cycle branch-taken/flush pulse to fetch/decode for JZ/JN/JC/JMP.
- Sits between the ALU and the EX/MEM boundary.

Parameters:
- CCR_W, 4, CCR width; bit order [3:NF, 2:OF, 1:CF, 0:ZF]; fixed, parameterised for readability only.

Ports:
- clk  in  1  system clock, rising edge
- rstN  in  1  asynchronous active-low reset
- aluSignals  in  5  ALU operation code of the instruction in EX (codebase ALU_* encodings)
- validEx  in  1  EX holds a real instruction, not a bubble
- stall  in  1  EX frozen this cycle; no state update
- flagsIn  in  4  ALU next flags {NF,OF,CF,ZF} (from negativeFlagOut, overFlowFlagOut, carryFlagOut, zeroFlagOut)
- intEntry  in  1  one-cycle pulse: interrupt accepted, CCR must be frozen
- flagsOut  out  4  current CCR, drives the ALU's zeroFlag/carryFlag/overFlowFlag/negativeFlag inputs
- freezedCCR  out  4  saved CCR, drives the ALU's freezedCCR input
- branchTaken  out  1  registered pulse: branch in EX resolved taken
- frozen  out  1  1 while a frozen copy is held (FSM in FROZEN)
- intOverrun  out  1  sticky: intEntry arrived while already FROZEN

Behaviour:
- Reset (rstN=0, async): CCR=0, freezedCCR=0, branchTaken=0, FSM=IDLE (frozen=0), intOverrun=0. Applies mid-operation with no completion of pending updates.
- Commit condition: commit = validEx & ~stall. No register changes without commit, except intEntry handling and the branchTaken clear.
- CCR update on commit:
  - CCR <= flagsIn. The ALU already passes through unchanged flags for non-flag ops and clears the tested flag for JZ/JN/JC.
  - ALU_NOP with validEx still writes flagsIn, which equals the current CCR.
- Branch resolution:
  - Evaluated combinationally on the pre-update CCR when commit is high.
  - JZ: taken=CCR[0]. JN: taken=CCR[3]. JC: taken=CCR[1]. JMP: taken=1. All other ops: taken=0.
  - branchTaken <= taken, registered, so it appears 1 cycle after the commit edge and is high for exactly 1 cycle.
  - branchTaken <= 0 on any cycle without commit.
- FSM:
  - IDLE -> FROZEN on intEntry: freezedCCR <= the value CCR holds after this edge (flagsIn if commit, else CCR).
  - FROZEN -> IDLE on commit with aluSignals==ALU_RTI: CCR <= flagsIn (the ALU drives freezedCCR through); freezedCCR keeps its value.
  - FROZEN + intEntry: no re-freeze; freezedCCR unchanged; intOverrun <= 1 (cleared only by reset).
  - FROZEN + RTI commit + intEntry in the same cycle: RTI wins (-> IDLE); intEntry is ignored and intOverrun is set.
  - IDLE + ALU_RTI commit: CCR <= flagsIn (stale freezedCCR); FSM stays IDLE; legal but undefined for software.
- Stall: holds CCR, freezedCCR and FSM; clears branchTaken; intEntry still honoured during stall.
- Latency: flagsOut reflects a committed update on the next cycle. There is no internal bypass; back-to-back flag dependences rely on this 1-cycle write.

Decomposition:
- Shared defines (defines.v): add CCR_ZF=0, CCR_CF=1, CCR_OF=2, CCR_NF=3 and FSM state codes CCR_IDLE, CCR_FROZEN; reuse the existing ALU_* opcode macros.
- One natural sub-module: branch_cond_eval, purely combinational (aluSignals, CCR -> taken). Keeps the decode table separately testable.

Test Plan:
- Reset: hold rstN=0 with flagsIn=4'hF and validEx=1 -> flagsOut=0, freezedCCR=0, branchTaken=0, frozen=0. Release, commit flagsIn=4'b0101 with ALU_ADD -> flagsOut=4'b0101 next cycle.
- Branch: CCR=4'b0001, commit JZ with flagsIn=4'b0000 -> branchTaken=1 for one cycle on the next cycle, flagsOut=0. Then JZ again -> branchTaken stays 0. JMP -> branchTaken=1.
- Stall: CCR=4'b1000, stall=1 with JN and flagsIn=0 -> flagsOut stays 4'b1000, branchTaken=0. Drop stall -> branchTaken pulses, flagsOut=0.
- Freeze/restore: CCR=4'b0110, intEntry with commit flagsIn=4'b0010 -> freezedCCR=4'b0010, frozen=1. Commit SETC (flagsIn=4'b0011) -> flagsOut=4'b0011. Commit RTI (flagsIn=4'b0010) -> flagsOut=4'b0010, frozen=0.
- Overrun: while frozen=1, pulse intEntry -> freezedCCR unchanged, intOverrun=1 and stays 1 after RTI. Same-cycle RTI+intEntry -> frozen=0, intOverrun=1.
- Async reset mid-FROZEN: assert rstN=0 between clock edges -> all outputs 0 immediately, without waiting for a clock edge.
